window_pixel_reader: RTL and testbench
======================================

// Module: window_pixel_reader
// PURPOSE
//  Parametrised successor to read_pixel. Fetches one (x,y) location, or its 3x3 neighbourhood, from NUM_CHANNELS
//  parallel single-port BRAMs (one per DoG/pyramid layer) sharing a single address. Streams the returned samples
//  with index tags to the SIFT extremum/keypoint logic. Sits between the DoG BRAM bank and the detector.
// PARAMETERS
//  BIT_DEPTH     9  signed sample width per channel
//  DIMENSION     4  image side length (pixels); >=2; address = y*DIMENSION + x
//  NUM_CHANNELS  2  number of BRAMs read in lockstep
//  READ_LATENCY  2  BRAM address->douta cycles (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY); >=1
// PORTS
//  clk          in   1                             clock
//  rst_in       in   1                             reset, asynchronous, active-high
//  input_ready  in   1                             request strobe; honoured only when busy=0
//  window_mode  in   1                             0: single pixel, 1: 3x3 window; sampled with input_ready
//  x, y         in   $clog2(DIMENSION)             centre coordinate; sampled with input_ready
//  address      out  $clog2(DIMENSION**2)          shared BRAM address, registered
//  data_in      in   [NUM_CHANNELS][BIT_DEPTH]     BRAM douta bus, channel c = BRAM c
//  pixel_out    out  [NUM_CHANNELS][BIT_DEPTH]     registered sample set
//  pixel_valid  out  1                             pixel_out/pixel_index/clamped valid this cycle
//  pixel_index  out  4                             0..8 raster index in window (dy major, dx minor); 0 in single mode
//  clamped      out  1                             this sample's coordinate was clamped at the border
//  busy         out  1                             request in flight
//  done         out  1                             1-cycle pulse, coincident with last pixel_valid
// BEHAVIOUR
//  Reset: all flops async-cleared; address=0, pixel_out=0, pixel_valid=0, pixel_index=0, clamped=0, busy=0,
//   done=0, FSM=IDLE. Reset mid-operation aborts the request; no done is produced; in-flight data is discarded.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE: at the edge where input_ready=1, latch mode/x/y, drive the first address (count N = 1 or 9),
//    set busy=1, go ISSUE (or DRAIN directly if N=1).
//   ISSUE: one new address per cycle until address N-1 has been driven, then DRAIN.
//   DRAIN: wait for the tag pipeline to empty; at the edge producing the last valid, assert done.
//    Next edge: done=0, busy=0, IDLE.
//  Request timing: an address driven at edge k has data_in valid after edge k+READ_LATENCY. It is captured into
//   pixel_out at edge k+READ_LATENCY+1.
//   First pixel_valid appears READ_LATENCY+1 cycles after acceptance. Valids are then back-to-back, N in total.
//  Window order: (dx,dy) in {-1,0,1}, index = (dy+1)*3 + (dx+1). Coordinate out of [0,DIMENSION-1] is clamped
//   to the edge (replicate); clamped=1 for that sample. Corners can clamp both axes.
//  Tags (index, clamped, valid) travel through a READ_LATENCY+1 stage delay line aligned with data.
//  input_ready while busy=1 is ignored (not queued). Min request spacing: N+READ_LATENCY+2 cycles.
//  Coordinate arithmetic uses $clog2(DIMENSION)+2-bit signed intermediates. No overflow.
//  pixel_out holds its last value when pixel_valid=0.
// STRUCTURE
//  sift_pkg: window_mode_e {MODE_SINGLE, MODE_WINDOW}; WINDOW_SIZE=9; localparam offset tables DX[9], DY[9].
//  Sub-module tag_delay_line #(WIDTH, DEPTH): resettable shift register carrying {valid,index,clamped}.
// TESTING  (DIMENSION=4, NUM_CHANNELS=2, READ_LATENCY=2; BRAM0[a]=a, BRAM1[a]=-a)
//  single (2,1) -> one valid 3 cycles after accept, pixel_out={6,-6}, index 0, done same cycle, busy low next.
//  window (1,1) -> 9 consecutive valids, ch0 = 0,1,2,4,5,6,8,9,10, clamped all 0, done on 9th.
//  window (0,0) -> ch0 = 0,0,1,0,0,1,4,4,5, clamped = 1,1,1,1,0,0,1,0,0.
//  window (3,3) -> ch0 = 10,11,11,14,15,15,14,15,15, clamped on indices 2,5,6,7,8.
//  input_ready pulsed mid-window -> ignored; exactly 9 valids, one done.
//  rst_in asserted after 4th valid -> all outputs 0 immediately, no done; new request completes normally.
//  Sweep all 16 single-mode (x,y) with back-to-back requests; check each value and spacing.
//  Rerun with READ_LATENCY=1.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared types and window offset tables for the SIFT pixel-fetch path.
// The offset tables list (dx,dy) in raster order, dy major and dx minor.
package sift_pkg;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_WINDOW = 1'b1
    } window_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

    localparam int WINDOW_SIZE = 9;
    localparam int CENTRE_INDEX = 4;

    localparam int DX [WINDOW_SIZE] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    localparam int DY [WINDOW_SIZE] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

    function automatic logic [3:0] last_index(input window_mode_e mode);
        return (mode == MODE_WINDOW) ? 4'(WINDOW_SIZE - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Resettable shift register that carries sample tags alongside BRAM read data.
// The tap output is one stage ahead of the final output.
module tag_delay_line #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tap  = stages[DEPTH-2];
    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/window_pixel_reader.sv
// Fetches one pixel or its 3x3 neighbourhood from a bank of lockstep BRAMs
// and streams the samples with index/clamp tags to the extremum detector.
module window_pixel_reader
    import sift_pkg::*;
#(
    parameter int BIT_DEPTH    = 9,
    parameter int DIMENSION    = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_in,
    input  logic                                      input_ready,
    input  logic                                      window_mode,
    input  logic [$clog2(DIMENSION)-1:0]              x,
    input  logic [$clog2(DIMENSION)-1:0]              y,
    output logic [$clog2(DIMENSION**2)-1:0]           address,
    input  logic [NUM_CHANNELS-1:0][BIT_DEPTH-1:0]    data_in,
    output logic [NUM_CHANNELS-1:0][BIT_DEPTH-1:0]    pixel_out,
    output logic                                      pixel_valid,
    output logic [3:0]                                pixel_index,
    output logic                                      clamped,
    output logic                                      busy,
    output logic                                      done
);

    localparam int CW = $clog2(DIMENSION);
    localparam int AW = $clog2(DIMENSION**2);
    localparam int SW = CW + 2;
    localparam int TW = 6;

    reader_state_e state, state_next;

    window_mode_e     mode_q;
    logic [CW-1:0]    x_q, y_q;
    logic [3:0]       count_q;

    logic             issue_en;
    window_mode_e     issue_mode;
    logic [CW-1:0]    issue_x, issue_y;
    logic [3:0]       issue_idx;
    logic [3:0]       tbl;
    logic signed [SW-1:0] sx, sy;
    logic [CW-1:0]    cx, cy;
    logic             clamp_x, clamp_y;
    logic [AW-1:0]    issue_addr;

    logic [TW-1:0]    tag_q, tag_tap, tag_out;
    logic             tap_valid;
    logic [3:0]       tap_idx;

    // In IDLE the request inputs feed the first address directly so it goes out on the accept edge.
    always_comb begin
        issue_en   = 1'b0;
        issue_mode = mode_q;
        issue_x    = x_q;
        issue_y    = y_q;
        issue_idx  = count_q;
        if (state == ST_IDLE) begin
            issue_en   = input_ready;
            issue_mode = window_mode_e'(window_mode);
            issue_x    = x;
            issue_y    = y;
            issue_idx  = 4'd0;
        end else if (state == ST_ISSUE) begin
            issue_en = 1'b1;
        end
    end

    always_comb begin
        tbl = (issue_mode == MODE_WINDOW) ? issue_idx : 4'(CENTRE_INDEX);
        sx  = $signed({2'b00, issue_x}) + SW'(DX[tbl]);
        sy  = $signed({2'b00, issue_y}) + SW'(DY[tbl]);

        cx      = sx[CW-1:0];
        clamp_x = 1'b0;
        if (sx < 0) begin
            cx      = '0;
            clamp_x = 1'b1;
        end else if (sx > SW'(DIMENSION - 1)) begin
            cx      = CW'(DIMENSION - 1);
            clamp_x = 1'b1;
        end

        cy      = sy[CW-1:0];
        clamp_y = 1'b0;
        if (sy < 0) begin
            cy      = '0;
            clamp_y = 1'b1;
        end else if (sy > SW'(DIMENSION - 1)) begin
            cy      = CW'(DIMENSION - 1);
            clamp_y = 1'b1;
        end

        issue_addr = AW'(cy) * AW'(DIMENSION) + AW'(cx);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (input_ready) begin
                    state_next = window_mode ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (count_q == 4'(WINDOW_SIZE - 1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            mode_q  <= MODE_SINGLE;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            address <= '0;
            tag_q   <= '0;
        end else begin
            tag_q <= {issue_en, issue_idx, clamp_x | clamp_y};
            if (issue_en) begin
                address <= issue_addr;
                count_q <= issue_idx + 4'd1;
            end
            if (state == ST_IDLE && input_ready) begin
                mode_q <= window_mode_e'(window_mode);
                x_q    <= x;
                y_q    <= y;
            end
        end
    end

    tag_delay_line #(
        .WIDTH (TW),
        .DEPTH (READ_LATENCY + 1)
    ) u_tags (
        .clk  (clk),
        .rst  (rst_in),
        .din  (tag_q),
        .tap  (tag_tap),
        .dout (tag_out)
    );

    assign tap_valid = tag_tap[5];
    assign tap_idx   = tag_tap[4:1];

    // The tap lines up with data_in, so capture and the done decision happen on the same edge.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pixel_out <= '0;
            done      <= 1'b0;
        end else begin
            if (tap_valid) begin
                pixel_out <= data_in;
            end
            done <= (state == ST_DRAIN) && tap_valid && (tap_idx == last_index(mode_q));
        end
    end

    assign pixel_valid = tag_out[5];
    assign pixel_index = tag_out[4:1];
    assign clamped     = tag_out[0];
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_window_pixel_reader.sv
// Directed bench driving two readers (READ_LATENCY 2 and 1) against modelled BRAMs
// holding a and -a at address a.
module tb_window_pixel_reader;

    localparam int RLAT [2] = '{2, 1};

    logic clk = 1'b0;
    logic rst_in;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic             ready [2];
    logic             mode  [2];
    logic [1:0]       xs    [2];
    logic [1:0]       ys    [2];
    logic [3:0]       addr  [2];
    logic [1:0][8:0]  din   [2];
    logic [1:0][8:0]  pout  [2];
    logic             pvalid [2];
    logic [3:0]       pidx  [2];
    logic             pclamp [2];
    logic             busy  [2];
    logic             done  [2];

    window_pixel_reader #(.BIT_DEPTH(9), .DIMENSION(4), .NUM_CHANNELS(2), .READ_LATENCY(2)) dut_rl2 (
        .clk(clk), .rst_in(rst_in), .input_ready(ready[0]), .window_mode(mode[0]),
        .x(xs[0]), .y(ys[0]), .address(addr[0]), .data_in(din[0]), .pixel_out(pout[0]),
        .pixel_valid(pvalid[0]), .pixel_index(pidx[0]), .clamped(pclamp[0]),
        .busy(busy[0]), .done(done[0])
    );

    window_pixel_reader #(.BIT_DEPTH(9), .DIMENSION(4), .NUM_CHANNELS(2), .READ_LATENCY(1)) dut_rl1 (
        .clk(clk), .rst_in(rst_in), .input_ready(ready[1]), .window_mode(mode[1]),
        .x(xs[1]), .y(ys[1]), .address(addr[1]), .data_in(din[1]), .pixel_out(pout[1]),
        .pixel_valid(pvalid[1]), .pixel_index(pidx[1]), .clamped(pclamp[1]),
        .busy(busy[1]), .done(done[1])
    );

    // BRAM models: address pipelines of depth READ_LATENCY feeding the douta buses.
    logic [3:0] pipe2 [2];
    logic [3:0] pipe1;

    always @(posedge clk) begin
        pipe2[0] <= addr[0];
        pipe2[1] <= pipe2[0];
        pipe1    <= addr[1];
    end

    function automatic logic [1:0][8:0] bramWord(input logic [3:0] a);
        logic [1:0][8:0] w;
        w[0] = {5'b0, a};
        w[1] = 9'd0 - {5'b0, a};
        return w;
    endfunction

    assign din[0] = bramWord(pipe2[1]);
    assign din[1] = bramWord(pipe1);

    typedef struct {
        int         cyc;
        logic [8:0] ch0;
        logic [8:0] ch1;
        logic [3:0] idx;
        logic       clamp;
        logic       done;
    } rec_t;

    rec_t recs0 [$];
    rec_t recs1 [$];
    int   doneCount [2];
    logic prevDone [2];
    logic busyAfterDone [2];

    always @(negedge clk) begin
        rec_t r;
        for (int d = 0; d < 2; d++) begin
            if (pvalid[d]) begin
                r.cyc   = cyc;
                r.ch0   = pout[d][0];
                r.ch1   = pout[d][1];
                r.idx   = pidx[d];
                r.clamp = pclamp[d];
                r.done  = done[d];
                if (d == 0) recs0.push_back(r);
                else        recs1.push_back(r);
            end
            if (done[d]) doneCount[d]++;
            if (prevDone[d]) busyAfterDone[d] = busy[d];
            prevDone[d] = done[d];
        end
    end

    function automatic int recCount(input int d);
        return (d == 0) ? recs0.size() : recs1.size();
    endfunction

    function automatic rec_t getRec(input int d, input int i);
        return (d == 0) ? recs0[i] : recs1[i];
    endfunction

    task automatic clearMon(input int d);
        if (d == 0) recs0.delete();
        else        recs1.delete();
        doneCount[d]     = 0;
        busyAfterDone[d] = 1'b1;
    endtask

    int nVectors = 0;
    int nMiscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkZero(input int d, input string name);
        string p;
        p = $sformatf("rl%0d_%s", RLAT[d], name);
        checkOutput({p, "_address"}, 32'(addr[d]), 0);
        checkOutput({p, "_pixel_out"}, 32'(pout[d]), 0);
        checkOutput({p, "_valid"}, 32'(pvalid[d]), 0);
        checkOutput({p, "_index"}, 32'(pidx[d]), 0);
        checkOutput({p, "_clamped"}, 32'(pclamp[d]), 0);
        checkOutput({p, "_busy"}, 32'(busy[d]), 0);
        checkOutput({p, "_done"}, 32'(done[d]), 0);
    endtask

    // Waits (bounded) for the reader to go idle, then presents one request for a single edge.
    task automatic applyStimulus(input int d, input logic m, input int px, input int py, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy[d] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (busy[d]) checkOutput($sformatf("rl%0d_idle_wait", RLAT[d]), 32'(busy[d]), 0);
        ready[d] = 1'b1;
        mode[d]  = m;
        xs[d]    = 2'(px);
        ys[d]    = 2'(py);
        @(posedge clk);
        #1;
        acc = cyc;
        ready[d] = 1'b0;
    endtask

    int expCh0   [9];
    int expClamp [9];

    task automatic runRequest(input int d, input logic m, input int px, input int py,
                              input int n, input int pulseAt, input string name);
        int acc;
        int nrec;
        rec_t r;
        logic [8:0] neg;
        string p;
        p = $sformatf("rl%0d_%s", RLAT[d], name);
        clearMon(d);
        applyStimulus(d, m, px, py, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == pulseAt) begin
                ready[d] = 1'b1;
                mode[d]  = 1'b0;
                xs[d]    = 2'd0;
                ys[d]    = 2'd0;
            end else begin
                ready[d] = 1'b0;
            end
        end
        ready[d] = 1'b0;
        #1;
        nrec = recCount(d);
        checkOutput({p, "_valid_count"}, 32'(nrec), 32'(n));
        checkOutput({p, "_done_count"}, 32'(doneCount[d]), 1);
        checkOutput({p, "_busy_after_done"}, 32'(busyAfterDone[d]), 0);
        checkOutput({p, "_busy_end"}, 32'(busy[d]), 0);
        for (int i = 0; i < n && i < nrec; i++) begin
            r   = getRec(d, i);
            neg = 9'(-expCh0[i]);
            checkOutput($sformatf("%s_ch0_%0d", p, i), 32'(r.ch0), 32'(expCh0[i]));
            checkOutput($sformatf("%s_ch1_%0d", p, i), 32'(r.ch1), 32'(neg));
            checkOutput($sformatf("%s_index_%0d", p, i), 32'(r.idx), m ? 32'(i) : 32'd0);
            checkOutput($sformatf("%s_clamped_%0d", p, i), 32'(r.clamp), 32'(expClamp[i]));
            checkOutput($sformatf("%s_cycle_%0d", p, i), 32'(r.cyc), 32'(acc + RLAT[d] + 1 + i));
            checkOutput($sformatf("%s_done_%0d", p, i), 32'(r.done), (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic resetDuringWindow(input int d);
        int acc;
        int guard;
        string p;
        p = $sformatf("rl%0d_rstmid", RLAT[d]);
        clearMon(d);
        applyStimulus(d, 1'b1, 1, 1, acc);
        guard = 0;
        @(negedge clk);
        #1;
        while (recCount(d) < 4 && guard < 30) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput({p, "_reached4"}, 32'(recCount(d)), 4);
        rst_in = 1'b1;
        #1;
        checkZero(d, "rstmid");
        @(negedge clk);
        rst_in = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        checkOutput({p, "_no_done"}, 32'(doneCount[d]), 0);
        checkOutput({p, "_no_more_valid"}, 32'(recCount(d)), 4);
        checkOutput({p, "_idle"}, 32'(busy[d]), 0);
    endtask

    task automatic sweepSingles(input int d);
        int accs [16];
        rec_t r;
        logic [8:0] neg;
        string p;
        p = $sformatf("rl%0d_sweep", RLAT[d]);
        clearMon(d);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(d, 1'b0, i % 4, i / 4, accs[i]);
        end
        repeat (10) @(negedge clk);
        #1;
        checkOutput({p, "_valid_count"}, 32'(recCount(d)), 16);
        checkOutput({p, "_done_count"}, 32'(doneCount[d]), 16);
        for (int i = 0; i < 16 && i < recCount(d); i++) begin
            r   = getRec(d, i);
            neg = 9'(-i);
            checkOutput($sformatf("%s_ch0_%0d", p, i), 32'(r.ch0), 32'(i));
            checkOutput($sformatf("%s_ch1_%0d", p, i), 32'(r.ch1), 32'(neg));
            checkOutput($sformatf("%s_index_%0d", p, i), 32'(r.idx), 0);
            checkOutput($sformatf("%s_cycle_%0d", p, i), 32'(r.cyc), 32'(accs[i] + RLAT[d] + 1));
            if (i > 0) begin
                checkOutput($sformatf("%s_spacing_%0d", p, i), 32'(accs[i] - accs[i-1]), 32'(RLAT[d] + 3));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            ready[d] = 1'b0;
            mode[d]  = 1'b0;
            xs[d]    = 2'd0;
            ys[d]    = 2'd0;
            prevDone[d] = 1'b0;
            clearMon(d);
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) checkZero(d, "reset");
        rst_in = 1'b0;

        for (int d = 0; d < 2; d++) begin
            expCh0   = '{6, 0, 0, 0, 0, 0, 0, 0, 0};
            expClamp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
            runRequest(d, 1'b0, 2, 1, 1, -1, "single21");

            expCh0   = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
            expClamp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
            runRequest(d, 1'b1, 1, 1, 9, -1, "win11");

            expCh0   = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
            expClamp = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
            runRequest(d, 1'b1, 0, 0, 9, -1, "win00");

            expCh0   = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
            expClamp = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
            runRequest(d, 1'b1, 3, 3, 9, -1, "win33");

            expCh0   = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
            expClamp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
            runRequest(d, 1'b1, 1, 1, 9, 2, "win11_pulse");

            resetDuringWindow(d);
            runRequest(d, 1'b1, 1, 1, 9, -1, "win11_after_rst");

            sweepSingles(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
